uart_tx_baud: RTL and testbench

UART_TX_BAUD -- requirements
Module: uart_tx_baud

---
 rtl/uart_tx_baud.sv | 156 +++++++++++++++
 tb/tb_uart_tx_baud.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_baud.sv
// Baud-rate UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_baud #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic [2:0]           state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] frame_q, frame_d;
   logic [DATA_BITS-1:0] shifted;
   logic                 tx_q, tx_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               state_d = S_START;
               cnt_d   = '0;
               idx_d   = '0;
               frame_d = data;
            end
         end
         S_START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            // The bit index doubles as the stop-bit counter.
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == STOP_LAST) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // NOTE: tx is decoded from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      shifted = frame_d >> idx_d;
      tx_d    = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shifted[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = (^frame_d) ^ 1'(PARITY_ODD);
`endif
         default:  tx_d = 1'b1;
      endcase
   end

`ifndef UART_TX_PARITY_EN
   logic unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
      end
   end

   // NOTE: the frame buffer is data-path only and is always loaded before use, so it has no reset.
   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = ~ready;
   assign tx    = tx_q;
   assign state = state_q;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Directed self-checking bench for uart_tx_baud: four instances with different parameters
// are driven together and every serial period is compared against a small frame model.
module tb_uart_tx_baud;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;

   logic [3:0] tx_v, ready_v, busy_v;
   logic [2:0] st_v [4];

   int n_checks = 0;
   int n_err    = 0;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int LEN_MAX = (1 + 8 + P + 2) * 4;

   always #5 clk = ~clk;

   uart_tx_baud #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
      .clk(clk), .reset(reset), .data(data), .valid(valid),
      .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .state(st_v[0]));
   uart_tx_baud #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset(reset), .data(data), .valid(valid),
      .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .state(st_v[1]));
   uart_tx_baud #(.DATA_BITS(5), .CLKS_PER_BIT(2), .STOP_BITS(1), .PARITY_ODD(0)) u2 (
      .clk(clk), .reset(reset), .data(data[4:0]), .valid(valid),
      .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .state(st_v[2]));
   uart_tx_baud #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) u3 (
      .clk(clk), .reset(reset), .data(data), .valid(valid),
      .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .state(st_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int db_of(input int i);  return (i == 2) ? 5 : 8; endfunction
   function automatic int cpb_of(input int i); return (i == 2) ? 2 : 4; endfunction
   function automatic int sb_of(input int i);  return (i == 1) ? 2 : 1; endfunction
   function automatic int po_of(input int i);  return (i == 3) ? 1 : 0; endfunction

   function automatic int frame_len(input int i);
      return (1 + db_of(i) + P + sb_of(i)) * cpb_of(i);
   endfunction

   // k = serial period counted from 1 right after the accept edge; outside the frame the line idles.
   function automatic logic exp_tx(input int i, input logic [7:0] d, input int k);
      int         bitn;
      logic [7:0] sh;
      logic [7:0] m;
      if (k < 1 || k > frame_len(i)) return 1'b1;
      bitn = (k - 1) / cpb_of(i);
      if (bitn == 0) return 1'b0;
      if (bitn <= db_of(i)) begin
         sh = d >> (bitn - 1);
         return sh[0];
      end
      if (P == 1 && bitn == db_of(i) + 1) begin
         m = d & 8'((1 << db_of(i)) - 1);
         return (^m) ^ 1'(po_of(i));
      end
      return 1'b1;
   endfunction

   function automatic logic exp_ready(input int i, input int k);
      return (k < 1 || k > frame_len(i));
   endfunction

   task automatic check_cycle(input int i, input logic [7:0] d, input int k);
      check($sformatf("u%0d d=%0h k=%0d tx", i, d, k), 32'(tx_v[i]), 32'(exp_tx(i, d, k)));
      check($sformatf("u%0d d=%0h k=%0d ready", i, d, k), 32'(ready_v[i]), 32'(exp_ready(i, k)));
      check($sformatf("u%0d d=%0h k=%0d busy", i, d, k), 32'(busy_v[i]), 32'(!exp_ready(i, k)));
   endtask

   // Sends d on all instances; a stray valid pulse mid-frame must be ignored. abort_at>0 resets mid-frame.
   task automatic run_frame(input logic [7:0] d, input int abort_at);
      valid = 1'b1;
      data  = d;
      @(posedge clk); #1;
      valid = 1'b0;
      data  = ~d;
      for (int k = 1; k <= LEN_MAX + 2; k++) begin
         for (int i = 0; i < 4; i++) check_cycle(i, d, k);
         if (k == 10) begin
            valid = 1'b1;
            data  = 8'hFF;
         end
         if (k == 11) begin
            valid = 1'b0;
            data  = ~d;
         end
         if (k == abort_at) begin
            #2 reset = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
               check($sformatf("u%0d async reset tx", i), 32'(tx_v[i]), 32'd1);
               check($sformatf("u%0d async reset state", i), 32'(st_v[i]), 32'd0);
               check($sformatf("u%0d async reset ready", i), 32'(ready_v[i]), 32'd1);
               check($sformatf("u%0d async reset busy", i), 32'(busy_v[i]), 32'd0);
            end
            #2 reset = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int l0;
      #12;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("u%0d reset tx", i), 32'(tx_v[i]), 32'd1);
         check($sformatf("u%0d reset ready", i), 32'(ready_v[i]), 32'd1);
         check($sformatf("u%0d reset busy", i), 32'(busy_v[i]), 32'd0);
         check($sformatf("u%0d reset state", i), 32'(st_v[i]), 32'd0);
      end
      #1 reset = 1'b0;

      // First accept on the first edge after reset release.
      run_frame(8'hA5, 0);
      run_frame(8'h00, 0);
      run_frame(8'h01, 0);
      run_frame(8'h1F, 0);
      run_frame(8'hFF, 0);

      // valid held high: two frames of u0 separated by a single idle clock.
      l0    = frame_len(0);
      valid = 1'b1;
      data  = 8'h3C;
      @(posedge clk); #1;
      data = 8'hC3;
      for (int k = 1; k <= 2 * l0 + 1; k++) begin
         if (k <= l0 + 1) begin
            check($sformatf("b2b k=%0d tx", k), 32'(tx_v[0]), 32'(exp_tx(0, 8'h3C, k)));
            check($sformatf("b2b k=%0d ready", k), 32'(ready_v[0]), 32'(exp_ready(0, k)));
         end else begin
            check($sformatf("b2b k=%0d tx", k), 32'(tx_v[0]), 32'(exp_tx(0, 8'hC3, k - l0 - 1)));
            check($sformatf("b2b k=%0d ready", k), 32'(ready_v[0]), 32'(exp_ready(0, k - l0 - 1)));
         end
         if (k == 2 * l0 + 1) valid = 1'b0;
         @(posedge clk); #1;
      end
      repeat (60) @(posedge clk);
      #1;

      // Reset while u0 is in data bit 3, then a clean frame on the first edge afterwards.
      run_frame(8'hA5, 18);
      #1;
      run_frame(8'h5A, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
